// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-multiplexes one combinational ALU between two
// valid/ready requesters. Operands and results are registered around the
// ALU. Each operation runs IDLE (accept) -> EXEC (ALU) -> RESP (hand back).
// Contention is resolved by a round-robin pointer.
module alu_share_arbiter #(
    parameter int DW = 32,
    parameter int SW = 5
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0_valid,
    input  logic [DW-1:0] req0_in1,
    input  logic [DW-1:0] req0_in2,
    input  logic [SW-1:0] req0_sig,
    output logic          req0_ready,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [DW-1:0] rsp0_data,
    output logic          rsp0_zero,
    output logic          rsp0_ovf,

    input  logic          req1_valid,
    input  logic [DW-1:0] req1_in1,
    input  logic [DW-1:0] req1_in2,
    input  logic [SW-1:0] req1_sig,
    output logic          req1_ready,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp1_data,
    output logic          rsp1_zero,
    output logic          rsp1_ovf,

    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [SW-1:0] alu_signal,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_zero,
    input  logic          alu_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic          ptr;        // requester favoured when both are valid
    logic          gid;        // requester owning the operation in flight
    logic [DW-1:0] op1_q;
    logic [DW-1:0] op2_q;
    logic [SW-1:0] sig_q;
    logic [DW-1:0] res_q;
    logic          zero_q;
    logic          ovf_q;
    logic          rsp0_valid_q;
    logic          rsp1_valid_q;

    logic          grant_any;
    logic          grant_id;
    logic          rsp_taken;

    // Pick the winner of this IDLE cycle; a lone requester always wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
                grant_id  = ptr;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_any && !grant_id;
    assign req1_ready = grant_any &&  grant_id;

    // The owner of the pending result has accepted it.
    assign rsp_taken = gid ? rsp1_ready : rsp0_ready;

    // Arbitration FSM with operand, result and response registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state        <= IDLE;
            ptr          <= 1'b0;
            gid          <= 1'b0;
            op1_q        <= '0;
            op2_q        <= '0;
            sig_q        <= '0;
            res_q        <= '0;
            zero_q       <= 1'b0;
            ovf_q        <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        gid   <= grant_id;
                        op1_q <= grant_id ? req1_in1 : req0_in1;
                        op2_q <= grant_id ? req1_in2 : req0_in2;
                        sig_q <= grant_id ? req1_sig : req0_sig;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_q        <= alu_out;
                    zero_q       <= alu_zero;
                    ovf_q        <= alu_ovf;
                    sig_q        <= '0;
                    rsp0_valid_q <= !gid;
                    rsp1_valid_q <= gid;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_taken) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        ptr          <= !gid;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The op code register is loaded only for the EXEC cycle, so the ALU
    // sees its neutral op code whenever no operation is executing.
    assign alu_in1    = op1_q;
    assign alu_in2    = op2_q;
    assign alu_signal = sig_q;

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = res_q;
    assign rsp0_zero  = zero_q;
    assign rsp0_ovf   = ovf_q;
    assign rsp1_data  = res_q;
    assign rsp1_zero  = zero_q;
    assign rsp1_ovf   = ovf_q;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single combinational ALU between two requesters: requester 0 is the main datapath and requester 1 is an auxiliary address/branch unit. Each requester uses a valid/ready request and response handshake. Operands are registered before they drive the ALU, and the ALU result is registered before it is returned. Conflicts are resolved round-robin. The block sits between the requesters and the ALU's alu_in1/alu_in2/alu_signal inputs and alu_out/zero/ovf outputs.

Parameters:
DW, 32, operand/result width
SW, 5, ALU operation code width (ALUSIGNAL_* encoding)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 has an operation
req0_in1  in  DW  operand 1
req0_in2  in  DW  operand 2
req0_sig  in  SW  ALU operation code
req0_ready  out  1  request 0 accepted this cycle
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 takes the result
rsp0_data  out  DW  result
rsp0_zero  out  1  zero flag
rsp0_ovf  out  1  overflow/carry flag
req1_*, rsp1_*  same set as requester 0, for requester 1
alu_in1  out  DW  to ALU
alu_in2  out  DW  to ALU
alu_signal  out  SW  to ALU
alu_out  in  DW  from ALU
alu_zero  in  1  from ALU
alu_ovf  in  1  from ALU

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst).
- State machine IDLE -> EXEC -> RESP -> IDLE. Reset forces IDLE.
- Reset values: all outputs 0, priority pointer = requester 0, operand/result registers 0, grant id 0.
- IDLE:
  - Winner is chosen combinationally.
  - Only one valid: that requester wins.
  - Both valid: the requester named by the pointer wins.
  - reqN_ready=1 for the winner only, in the same cycle. The winner's operands, op code and id are latched. Next state is EXEC.
  - No valid: stay in IDLE, both ready=0.
- reqN_ready is only ever asserted in IDLE.
- A requester must hold its payload stable while valid && !ready. A loser keeps valid asserted and is served later.
- EXEC (exactly 1 cycle):
  - alu_in1/alu_in2/alu_signal are driven from the latched registers.
  - alu_out/alu_zero/alu_ovf are captured into the result registers at the end of the cycle.
  - Next state is RESP.
- Outside EXEC: alu_signal=0 (the ALU default yields a zero result); alu_in1/alu_in2 hold the last latched values.
- RESP:
  - rspN_valid=1 for the granted id only, and rsp data/flags are stable.
  - On rspN_ready=1: the pointer is set to the other requester, next state is IDLE.
  - Otherwise stay in RESP indefinitely (backpressure). No new request is accepted while in RESP.
- Latency: request accepted at cycle T -> rsp_valid at T+2 -> earliest next accept at T+3 (one op per 3 cycles at best).
- Fairness: under continuous requests from both, grants alternate 0,1,0,1. A lone requester is served back-to-back regardless of the pointer.
- Flags: the zero/ovf values from the ALU are passed through unchanged. The block does not interpret the op code.
- Reset in EXEC or RESP: the operation is discarded, no rsp_valid is asserted afterwards, and the pointer returns to 0.
- rsp_valid for both requesters is never asserted in the same cycle. reqN_ready is never asserted in the same cycle as any rsp_valid.

Test Plan:
- Reset, then req0 ADDU in1=7 in2=9, rsp0_ready=1 -> req0_ready at T, alu_signal=ADDU in T+1, rsp0_valid at T+2 with data=0x10, zero=0, ovf=0; rsp1_valid stays 0.
- req1 SUBU 0x20,0x20 -> rsp1_data=0, rsp1_zero=1. Then req1 ADDU 0xFFFFFFFF,1 -> data=0, zero=1, ovf=1.
- Both valid continuously for 4 ops (req0 OR 0xF0,0x0F; req1 AND 0xFF,0x0F) -> grant order 0,1,0,1; results 0xFF and 0x0F; loser's ready stays 0 until its turn.
- Backpressure: rsp0_ready=0 for 5 cycles -> rsp0_valid and data held stable, req1_ready=0 throughout although req1_valid=1; req1 is granted in the first IDLE cycle after rsp0_ready=1.
- Assert rst during EXEC -> next cycle all outputs 0, no rsp_valid afterwards; a subsequent simultaneous request grants requester 0 first.
- Idle with no valid for 10 cycles -> alu_signal=0, both ready=0, both rsp_valid=0.
